decode_reg_scoreboard: RTL and testbench
========================================

// Module: decode_reg_scoreboard
// PURPOSE
//  Registered decode stage: turns an instr_packet into reg_file_read_params_t (rs1/rs2/rd) plus use/write flags.
//  Holds each instruction in a one-entry stage register. A per-register pending-write scoreboard stalls RAW
//  and WAW hazards. Sits between fetch and the register-file read/execute stage; completions arrive from writeback.
// PARAMETERS
//  REG_ADDR_WIDTH  5  register index width; 5 = 32 regs (RV32I), 4 = 16 regs (RV32E)
//  PEND_CNT_WIDTH  2  per-register pending-write counter width; max outstanding writes per reg = 2**W-1
// PORTS
//  clk         in   1               clock, all state on rising edge
//  rst_n       in   1               asynchronous reset, active low
//  in_valid    in   1               upstream instruction valid
//  in_ready    out  1               stage can accept
//  in_instr    in   instr_packet    instruction to decode
//  out_valid   out  1               decoded params valid and hazard-free
//  out_ready   in   1               downstream accepts
//  out_params  out  reg_file_read_params_t  rs1/rs2/rd (REG_ADDR_WIDTH each)
//  out_rd_we   out  1               instruction writes rd (rd != x0)
//  wb_valid    in   1               writeback completion
//  wb_rd       in   REG_ADDR_WIDTH  register completed
//  flush       in   1               discard held instruction (scoreboard kept)
//  busy        out  1               any pending counter nonzero
// BEHAVIOUR
//  Decode (combinational, on in_instr):
//  - rd = r_instr.rd, rs2 = r_instr.rs2, rs1 = r_instr.rs1.
//  - rs1 = x0 for OPCODE_LUI and for OPCODE_SYSTEM with funct3.input_select == CSR_SEL_IMM.
//  - use_rs1: all opcodes except LUI, AUIPC, JAL, CSRxI. use_rs2: OP, STORE, BRANCH only.
//  - rd_we: LUI, AUIPC, JAL, JALR, LOAD, OP, OP_IMM, SYSTEM(csr); forced 0 when rd == x0.
//  - Indices wider than REG_ADDR_WIDTH are truncated; RV32E ignores the upper bit.
//  Stage register: held_valid, params, use flags, rd_we. On reset: held_valid=0, params=0, rd_we=0.
//  - load when in_valid & in_ready; fire = out_valid & out_ready.
//  - in_ready = !held_valid | fire. Min latency 1 cycle, full throughput when hazard-free.
//  - hazard = (use_rs1 & pend[rs1]!=0) | (use_rs2 & pend[rs2]!=0) | (rd_we & pend[rd]==MAX).
//  - out_valid = held_valid & !hazard & !flush. out_params/out_rd_we stable while out_valid & !out_ready.
//  - x0 is never pending; pend[0] is hardwired 0.
//  Scoreboard: 2**REG_ADDR_WIDTH counters, reset 0.
//  - +1 on fire & out_rd_we to out_params.rd; -1 on wb_valid to wb_rd.
//  - Both on the same reg in the same cycle: net unchanged.
//  - wb_valid to a zero counter (or to x0): ignored, no underflow. A saturated counter blocks issue (no overflow).
//  - busy = OR of all counters != 0; reset 0.
//  flush: clears held_valid next edge; in_ready held 0 that cycle; counters untouched.
//  rst_n low mid-operation: all state cleared asynchronously; outputs 0 until the first post-reset load.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN defined: the hazard check uses pend minus a matching wb_valid this cycle.
//  - A pend of 1 released by writeback issues in the same cycle.
//  Undefined: hazard uses registered pend only; issue happens one cycle after writeback.
// TESTING
//  1 reset, then ADDI x5,x0,1 -> out_valid next cycle, rs1=0, rd=5, out_rd_we=1; after fire pend[5]=1, busy=1.
//  2 ADD x6,x5,x5 with pend[5]=1 -> out_valid=0; wb_valid,wb_rd=5 -> out_valid same cycle with _EN, next cycle without.
//  3 LUI x7 with rs1 field=9, pend[9]=1 -> issues without stall, rs1=0; CSRRWI rs1 field=3 -> rs1=0, no stall.
//  4 ADDI x0,x1,0 fire -> out_rd_we=0, pend unchanged; wb_valid,wb_rd=0 -> no change.
//  5 PEND_CNT_WIDTH=1: second write to x8 stalls until wb to x8; fire and wb to x8 in one cycle -> pend stays 1.
//  6 held stalled instr + flush -> out_valid=0, held cleared, pend kept; rst_n pulse mid-stall -> all outputs 0.

Source files
------------

// File: rtl/decode_reg_scoreboard_if.sv
// Decode stage shared types and the fetch/decode/issue handshake bundle.
// Instruction packet mirrors the 32-bit RISC-V encoding field order.
package decode_reg_scoreboard_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;
  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

  localparam logic CSR_SEL_IMM = 1'b1;

  typedef struct packed {
    logic       input_select;
    logic [1:0] op;
  } funct3_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    funct3_t    funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_packet;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } reg_file_read_params_t;

endpackage

interface decode_reg_scoreboard_if;
  import decode_reg_scoreboard_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  instr_packet           in_instr;
  logic                  out_valid;
  logic                  out_ready;
  reg_file_read_params_t out_params;
  logic                  out_rd_we;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_params, out_rd_we
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_params, out_rd_we
  );

endinterface

// File: rtl/decode_reg_scoreboard.sv
// Registered decode stage with per-register pending-write scoreboard.
// Optional DECODE_WB_BYPASS_EN lets a same-cycle writeback release a hazard.
module decode_reg_scoreboard
  import decode_reg_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int PEND_CNT_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  decode_reg_scoreboard_if.slave    bus,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic                      flush,
  output logic                      busy
);

  localparam int AW   = REG_ADDR_WIDTH;
  localparam int CW   = PEND_CNT_WIDTH;
  localparam int NREG = 1 << AW;
  localparam logic [CW-1:0] MAX = '1;

  instr_packet ins;
  assign ins = bus.in_instr;

  logic unused_funct7;
  assign unused_funct7 = ^ins.funct7;

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_load, is_store, is_branch;
  logic is_op, is_op_imm, is_sys, csr_imm;

  assign is_lui    = ins.opcode == OPCODE_LUI;
  assign is_auipc  = ins.opcode == OPCODE_AUIPC;
  assign is_jal    = ins.opcode == OPCODE_JAL;
  assign is_jalr   = ins.opcode == OPCODE_JALR;
  assign is_load   = ins.opcode == OPCODE_LOAD;
  assign is_store  = ins.opcode == OPCODE_STORE;
  assign is_branch = ins.opcode == OPCODE_BRANCH;
  assign is_op     = ins.opcode == OPCODE_OP;
  assign is_op_imm = ins.opcode == OPCODE_OP_IMM;
  assign is_sys    = ins.opcode == OPCODE_SYSTEM;
  assign csr_imm   = is_sys &&
    (ins.funct3.input_select == CSR_SEL_IMM);

  logic [AW-1:0] d_rs1, d_rs2, d_rd;
  logic          d_use1, d_use2, d_we, we_raw;

  always_comb begin
    d_rd   = ins.rd[AW-1:0];
    d_rs2  = ins.rs2[AW-1:0];
    d_rs1  = (is_lui || csr_imm) ? '0 : ins.rs1[AW-1:0];
    d_use1 = 1'b1;
    d_use2 = 1'b0;
    we_raw = 1'b0;
    unique case (1'b1)
      is_lui, is_auipc, is_jal: begin
        d_use1 = 1'b0;
        we_raw = 1'b1;
      end
      is_jalr, is_load, is_op_imm: we_raw = 1'b1;
      is_op: begin
        d_use2 = 1'b1;
        we_raw = 1'b1;
      end
      is_store, is_branch: d_use2 = 1'b1;
      is_sys: begin
        d_use1 = !csr_imm;
        we_raw = |ins.funct3.op;
      end
      default: d_use1 = 1'b1;
    endcase
    d_we = we_raw && (d_rd != '0);
  end

  logic          held;
  logic [AW-1:0] r_rs1, r_rs2, r_rd;
  logic          r_use1, r_use2, r_we;
  logic [CW-1:0] pend [NREG];

  logic [CW-1:0] cnt1, cnt2, cntd;
  logic          rel1, rel2, reld;
  logic          hazard, fire, load;

  assign cnt1 = pend[r_rs1];
  assign cnt2 = pend[r_rs2];
  assign cntd = pend[r_rd];

`ifdef DECODE_WB_BYPASS_EN
  assign rel1 = wb_valid && (wb_rd == r_rs1) && (cnt1 != '0);
  assign rel2 = wb_valid && (wb_rd == r_rs2) && (cnt2 != '0);
  assign reld = wb_valid && (wb_rd == r_rd) && (cntd != '0);
`else
  assign rel1 = 1'b0;
  assign rel2 = 1'b0;
  assign reld = 1'b0;
`endif

  assign hazard =
    (r_use1 && ((cnt1 - CW'(rel1)) != '0)) ||
    (r_use2 && ((cnt2 - CW'(rel2)) != '0)) ||
    (r_we && ((cntd - CW'(reld)) == MAX));

  assign bus.out_valid  = held && !hazard && !flush;
  assign fire           = bus.out_valid && bus.out_ready;
  assign bus.in_ready   = (!held || fire) && !flush;
  assign load           = bus.in_valid && bus.in_ready;
  assign bus.out_rd_we  = r_we;
  assign bus.out_params = '{
    rs1: 5'(r_rs1),
    rs2: 5'(r_rs2),
    rd:  5'(r_rd)
  };

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held   <= 1'b0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
      r_use1 <= 1'b0;
      r_use2 <= 1'b0;
      r_we   <= 1'b0;
    end else begin
      if (flush)     held <= 1'b0;
      else if (load) held <= 1'b1;
      else if (fire) held <= 1'b0;
      if (load) begin
        r_rs1  <= d_rs1;
        r_rs2  <= d_rs2;
        r_rd   <= d_rd;
        r_use1 <= d_use1;
        r_use2 <= d_use2;
        r_we   <= d_we;
      end
    end
  end

  logic [NREG-1:0] inc, dec;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = fire && r_we && (r_rd == AW'(i));
      dec[i] = wb_valid && (wb_rd == AW'(i)) &&
               (pend[i] != '0);
    end
  end

  // Saturation never overflows: the hazard check blocks issue at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (i == 0)
          pend[i] <= '0;
        else if (inc[i] && !dec[i])
          pend[i] <= pend[i] + 1'b1;
        else if (dec[i] && !inc[i])
          pend[i] <= pend[i] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NREG; i++)
      busy = busy | (pend[i] != '0);
  end

endmodule

// File: tb/tb_decode_reg_scoreboard.sv
// Directed bench for decode_reg_scoreboard: decode, hazards, saturation,
// flush and async reset on a default instance plus a 1-bit-counter instance.
module tb_decode_reg_scoreboard;
  import decode_reg_scoreboard_pkg::*;

`ifdef DECODE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_valid, wb1_valid;
  logic [4:0] wb_rd, wb1_rd;
  logic       flush, flush1;
  logic       busy, busy1;
  int         checks = 0;
  int         errors = 0;

  decode_reg_scoreboard_if bus ();
  decode_reg_scoreboard_if bus1 ();

  decode_reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .busy(busy)
  );

  decode_reg_scoreboard #(.PEND_CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .wb_valid(wb1_valid), .wb_rd(wb1_rd),
    .flush(flush1), .busy(busy1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input logic [6:0] opc,
    input logic [4:0] rd, input logic [2:0] f3,
    input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, opc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] r);
    wb_valid = 1'b1;
    wb_rd    = r;
    tick();
    wb_valid = 1'b0;
  endtask

  // Load one instruction and let it fire; a stuck stage is an error.
  task automatic issue(input bit sel, input logic [31:0] ins);
    bit done = 0;
    if (sel) begin
      bus1.in_valid = 1'b1; bus1.in_instr = ins; bus1.out_ready = 1'b1;
    end else begin
      bus.in_valid = 1'b1; bus.in_instr = ins; bus.out_ready = 1'b1;
    end
    tick();
    bus.in_valid = 1'b0; bus1.in_valid = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      done = sel ? bus1.out_valid : bus.out_valid;
      tick();
    end
    bus.out_ready = 1'b0; bus1.out_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: got no fire want fire for %h", ins);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_params !== 15'd0) begin errors++;
      $display("FAIL rst_params: got %h want 0", bus.out_params); end
    checks++; if (bus.out_rd_we !== 1'b0) begin errors++;
      $display("FAIL rst_we: got %b want 0", bus.out_rd_we); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_OP_IMM, 5'd5, 3'd0, 5'd0, 5'd1);
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL addi_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL addi_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_params.rs1 !== 5'd0 || bus.out_params.rd !== 5'd5)
      begin errors++; $display("FAIL addi_params: got rs1=%0d rd=%0d want 0 5",
        bus.out_params.rs1, bus.out_params.rd); end
    checks++; if (bus.out_rd_we !== 1'b1) begin errors++;
      $display("FAIL addi_we: got %b want 1", bus.out_rd_we); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL addi_drained: got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b1 || dut.pend[5] !== 2'd1) begin errors++;
      $display("FAIL addi_pend: got busy=%b pend=%0d want 1 1",
        busy, dut.pend[5]); end
  endtask

  task automatic test_raw();
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_OP, 5'd6, 3'd0, 5'd5, 5'd5);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL raw_stall: got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL raw_stall_hold: got %b want 0", bus.out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    checks++; if (bus.out_valid !== BYP) begin errors++;
      $display("FAIL raw_wb_same: got %b want %b", bus.out_valid, BYP); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_params.rs2 !== 5'd5)
      begin errors++; $display("FAIL raw_release: got v=%b rs2=%0d want 1 5",
        bus.out_valid, bus.out_params.rs2); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (dut.pend[6] !== 2'd1 || dut.pend[5] !== 2'd0) begin errors++;
      $display("FAIL raw_pend: got p6=%0d p5=%0d want 1 0",
        dut.pend[6], dut.pend[5]); end
    wb(5'd6);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL raw_idle: got %b want 0", busy); end
  endtask

  task automatic test_lui_csr();
    issue(0, enc(OPCODE_OP_IMM, 5'd9, 3'd0, 5'd0, 5'd0));
    issue(0, enc(OPCODE_OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0));
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_LUI, 5'd7, 3'd0, 5'd9, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_params.rs1 !== 5'd0)
      begin errors++; $display("FAIL lui_issue: got v=%b rs1=%0d want 1 0",
        bus.out_valid, bus.out_params.rs1); end
    checks++; if (bus.out_rd_we !== 1'b1) begin errors++;
      $display("FAIL lui_we: got %b want 1", bus.out_rd_we); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_SYSTEM, 5'd10, 3'b101, 5'd3, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_params.rs1 !== 5'd0)
      begin errors++; $display("FAIL csrrwi_issue: got v=%b rs1=%0d want 1 0",
        bus.out_valid, bus.out_params.rs1); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (dut.pend[7] !== 2'd1 || dut.pend[10] !== 2'd1) begin
      errors++; $display("FAIL lui_csr_pend: got p7=%0d p10=%0d want 1 1",
        dut.pend[7], dut.pend[10]); end
    wb(5'd9); wb(5'd3); wb(5'd7); wb(5'd10);
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL lui_csr_idle: got %b want 0", busy); end
  endtask

  task automatic test_x0();
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_OP_IMM, 5'd0, 3'd0, 5'd1, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_rd_we !== 1'b0) begin
      errors++; $display("FAIL x0_we: got v=%b we=%b want 1 0",
        bus.out_valid, bus.out_rd_we); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL x0_busy: got %b want 0", busy); end
    wb(5'd0);
    wb(5'd4);
    checks++; if (busy !== 1'b0 || dut.pend[4] !== 2'd0) begin errors++;
      $display("FAIL wb_underflow: got busy=%b p4=%0d want 0 0",
        busy, dut.pend[4]); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_OP_IMM, 5'd12, 3'd0, 5'd0, 5'd0);
    tick();
    bus.in_instr = enc(OPCODE_OP_IMM, 5'd13, 3'd0, 5'd0, 5'd0);
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
      bus.out_params.rd !== 5'd12) begin errors++;
      $display("FAIL b2b_first: got v=%b rdy=%b rd=%0d want 1 1 12",
        bus.out_valid, bus.in_ready, bus.out_params.rd); end
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_params.rd !== 5'd13)
      begin errors++; $display("FAIL b2b_second: got v=%b rd=%0d want 1 13",
        bus.out_valid, bus.out_params.rd); end
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || dut.pend[12] !== 2'd1 ||
      dut.pend[13] !== 2'd1) begin errors++;
      $display("FAIL b2b_pend: got v=%b p12=%0d p13=%0d want 0 1 1",
        bus.out_valid, dut.pend[12], dut.pend[13]); end
    wb(5'd12); wb(5'd13);
  endtask

  task automatic test_same_cycle();
    issue(0, enc(OPCODE_OP_IMM, 5'd15, 3'd0, 5'd0, 5'd0));
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_OP_IMM, 5'd15, 3'd0, 5'd0, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL waw_below_max: got %b want 1", bus.out_valid); end
    bus.out_ready = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd15;
    tick();
    bus.out_ready = 1'b0;
    wb_valid = 1'b0;
    checks++; if (dut.pend[15] !== 2'd1) begin errors++;
      $display("FAIL same_cycle_net: got %0d want 1", dut.pend[15]); end
    wb(5'd15);
  endtask

  task automatic test_saturate();
    issue(1, enc(OPCODE_OP_IMM, 5'd8, 3'd0, 5'd0, 5'd0));
    checks++; if (dut1.pend[8] !== 1'b1) begin errors++;
      $display("FAIL sat_first: got %0d want 1", dut1.pend[8]); end
    bus1.in_valid = 1'b1;
    bus1.in_instr = enc(OPCODE_OP_IMM, 5'd8, 3'd0, 5'd0, 5'd0);
    tick();
    bus1.in_valid = 1'b0;
    #1;
    checks++; if (bus1.out_valid !== 1'b0) begin errors++;
      $display("FAIL sat_stall: got %b want 0", bus1.out_valid); end
    bus1.out_ready = 1'b1;
    wb1_valid = 1'b1; wb1_rd = 5'd8;
    #1;
    checks++; if (bus1.out_valid !== BYP) begin errors++;
      $display("FAIL sat_wb_same: got %b want %b", bus1.out_valid, BYP); end
    tick();
    wb1_valid = 1'b0;
    #1;
    checks++; if (bus1.out_valid !== !BYP) begin errors++;
      $display("FAIL sat_after_wb: got %b want %b", bus1.out_valid, !BYP); end
    tick();
    bus1.out_ready = 1'b0;
    checks++; if (dut1.pend[8] !== 1'b1 || busy1 !== 1'b1) begin errors++;
      $display("FAIL sat_pend: got p8=%0d busy=%b want 1 1",
        dut1.pend[8], busy1); end
    wb1_valid = 1'b1; wb1_rd = 5'd8;
    tick();
    wb1_valid = 1'b0;
    checks++; if (busy1 !== 1'b0) begin errors++;
      $display("FAIL sat_idle: got %b want 0", busy1); end
  endtask

  task automatic test_flush_reset();
    issue(0, enc(OPCODE_OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0));
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_SYSTEM, 5'd11, 3'b001, 5'd3, 5'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL csrrw_stall: got %b want 0", bus.out_valid); end
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_cycle: got rdy=%b v=%b want 0 0",
        bus.in_ready, bus.out_valid); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b1 ||
      dut.pend[3] !== 2'd1) begin errors++;
      $display("FAIL flush_after: got rdy=%b busy=%b p3=%0d want 1 1 1",
        bus.in_ready, busy, dut.pend[3]); end
    wb(5'd3);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL flush_dropped: got v=%b busy=%b want 0 0",
        bus.out_valid, busy); end
    bus.out_ready = 1'b0;
    issue(0, enc(OPCODE_OP_IMM, 5'd3, 3'd0, 5'd0, 5'd0));
    bus.in_valid = 1'b1;
    bus.in_instr = enc(OPCODE_SYSTEM, 5'd11, 3'b001, 5'd3, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_params.rd !== 5'd11 || bus.out_valid !== 1'b0)
      begin errors++; $display("FAIL pre_rst_held: got rd=%0d v=%b want 11 0",
        bus.out_params.rd, bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_params !== 15'd0 ||
      bus.out_rd_we !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL async_rst: got v=%b p=%h we=%b busy=%b want 0 0 0 0",
        bus.out_valid, bus.out_params, bus.out_rd_we, busy); end
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_params !== 15'd0 ||
      busy !== 1'b0) begin errors++;
      $display("FAIL post_rst: got v=%b p=%h busy=%b want 0 0 0",
        bus.out_valid, bus.out_params, busy); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_instr = '0; bus1.out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    wb1_valid = 1'b0; wb1_rd = '0; flush1 = 1'b0;
    test_reset();
    test_addi();
    test_raw();
    test_lui_csr();
    test_x0();
    test_back_to_back();
    test_same_cycle();
    test_saturate();
    test_flush_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
